// File: rtl/issue_if.sv
// -----------------------------------------------------------------------------
// issue_if: generic valid/ready channel carrying a flat data word.
//
// Parameters:
//   W      data word width
// Signals:
//   valid  producer has a word on data this cycle
//   ready  consumer takes the word when valid && ready at the rising clock edge
//   data   payload; its field layout is defined by the module using the channel
// Modports:
//   master drives valid/data, samples ready
//   slave  samples valid/data, drives ready
// -----------------------------------------------------------------------------
interface issue_if #(
  parameter int W = 1
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/issue.sv
// -----------------------------------------------------------------------------
// issue: in-order single-issue stage between decode and execute.
//
// Owns the integer register file and a per-register busy scoreboard. A decoded
// instruction is accepted when the one-entry output register is free and none
// of its source or destination registers has a pending write; the accepted
// instruction and its operand values appear on the issued channel next cycle.
// Execute results come back on the writeback port.
//
// Parameters:
//   XLEN   register / operand width
//   NREG   architectural register count (x0 reads as zero, never written)
// Ports:
//   clk       clock, all state changes on the rising edge
//   rst       synchronous active-high reset
//   decoded   slave channel, data = {op[6:0], rd[4:0], rs1[4:0], rs2[4:0]}
//             (instance width 22)
//   issued    master channel, data = {op, rd, rs1, rs2, rs1_val, rs2_val}
//             (instance width 22 + 2*XLEN)
//   wb_valid  a result is written back this cycle
//   wb_rd     writeback destination (0 is ignored)
//   wb_value  writeback value
//   flush     drop the held instruction and clear the scoreboard
//
// Build option:
//   ISSUE_BYPASS_EN  when defined, a same-cycle writeback both lifts the hazard
//                    on its register and supplies the operand value directly.
//                    When undefined, hazards look only at the scoreboard and
//                    operands come only from the register file.
// -----------------------------------------------------------------------------
module issue #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  issue_if.slave          decoded,
  issue_if.master         issued,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_value,
  input  logic            flush
);
  localparam int OPW = 7;
  localparam int RW  = 5;
  localparam int IW  = OPW + 3 * RW + 2 * XLEN;

  // Decoded fields
  logic [OPW-1:0] d_op;
  logic [RW-1:0]  d_rd;
  logic [RW-1:0]  d_rs1;
  logic [RW-1:0]  d_rs2;
  assign {d_op, d_rd, d_rs1, d_rs2} = decoded.data;

  // State
  logic [XLEN-1:0] regfile [NREG];
  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;
  logic            out_valid_reg;
  logic [IW-1:0]   out_data_reg;

  logic wb_en;
  assign wb_en = wb_valid && (wb_rd != '0);

  // Same-cycle forwarding matches (wb_en already excludes x0)
  logic fwd_rs1, fwd_rs2, fwd_rd;
`ifdef ISSUE_BYPASS_EN
  assign fwd_rs1 = wb_en && (wb_rd == d_rs1);
  assign fwd_rs2 = wb_en && (wb_rd == d_rs2);
  assign fwd_rd  = wb_en && (wb_rd == d_rd);
`else
  assign fwd_rs1 = 1'b0;
  assign fwd_rs2 = 1'b0;
  assign fwd_rd  = 1'b0;
`endif

  logic haz_rs1, haz_rs2, haz_rd, out_free, dec_ready, accept;
  assign haz_rs1   = (d_rs1 != '0) && busy_reg[d_rs1] && !fwd_rs1;
  assign haz_rs2   = (d_rs2 != '0) && busy_reg[d_rs2] && !fwd_rs2;
  assign haz_rd    = (d_rd  != '0) && busy_reg[d_rd]  && !fwd_rd;
  assign out_free  = !out_valid_reg || issued.ready;
  assign dec_ready = out_free && !haz_rs1 && !haz_rs2 && !haz_rd && !flush;
  assign accept    = decoded.valid && dec_ready;

  assign decoded.ready = dec_ready;
  assign issued.valid  = out_valid_reg;
  assign issued.data   = out_data_reg;

  // Operand selection: x0 is zero, a forwarded result beats the stale regfile
  logic [XLEN-1:0] rs1_val, rs2_val;
  always_comb begin
    rs1_val = '0;
    if (d_rs1 != '0) rs1_val = fwd_rs1 ? wb_value : regfile[d_rs1];
  end
  always_comb begin
    rs2_val = '0;
    if (d_rs2 != '0) rs2_val = fwd_rs2 ? wb_value : regfile[d_rs2];
  end

  // Scoreboard next state. The accept term is ORed after the writeback clear
  // so a same-index set in the same cycle wins. x0 is never marked busy.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        assign busy_next[gi] = !flush &&
          ((accept && (d_rd == RW'(gi))) ||
           (busy_reg[gi] && !(wb_en && (wb_rd == RW'(gi)))));
      end
    end
  endgenerate

  // Register file: one write port; flush does not suppress writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regfile[i] <= '0;
    end else if (wb_en) begin
      regfile[wb_rd] <= wb_value;
    end
  end

  // Scoreboard and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      busy_reg <= busy_next;
      if (flush) begin
        out_valid_reg <= 1'b0;
      end else if (accept) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= {decoded.data, rs1_val, rs2_val};
      end else if (issued.ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end
endmodule

// File: doc/issue.md
# issue

In-order single-issue stage between decode and execute. Accepts one decoded instruction per cycle, reads source operands from the integer register file it owns, and tracks pending destination writes in a scoreboard. Instructions with a register hazard stall; a one-entry output register then presents the instruction plus operand values to execute. Execute results return through the writeback port, which updates the register file and clears scoreboard bits.

## Interface

Parameters:
- XLEN, 32, register and operand width.
- NREG, 32, architectural register count; index 0 is hardwired zero.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- decoded  decoupled.in  decoded_instr  from decode. Uses fields op, rs1, rs2, rd (5 b each for registers); rd==0 means "no write".
- issued  decoupled.out  issued_instr  to execute. Carries the decoded_instr fields plus rs1_val and rs2_val (XLEN each).
- wb_valid  in  1  execute result writes a register this cycle.
- wb_rd  in  5  destination index; writes with wb_rd==0 are ignored.
- wb_value  in  XLEN  result value.
- flush  in  1  kill the held instruction and reset the scoreboard.

## Operation

- State: regfile[NREG] of XLEN bits; busy[NREG]; out_valid; out_data.
- Reset: regfile all 0, busy all 0, out_valid 0. issued.valid is 0 in the cycle after reset is asserted.
- Source hazard: rsN!=0 and busy[rsN] and not (wb_valid and wb_rd==rsN).
- WAW hazard: rd!=0 and busy[rd] and not (wb_valid and wb_rd==rd).
- Output free: !out_valid or issued.ready.
- decoded.ready = output free && !hazard && !flush. This is combinational and depends on decoded.data.
- Accept (decoded.valid && decoded.ready):
  - Load out_data with the decoded fields.
  - Operand = 0 if rsN==0; else wb_value if wb_valid and wb_rd==rsN; else regfile[rsN].
  - Set busy[rd] if rd!=0.
- Writeback with wb_valid and wb_rd!=0: write regfile[wb_rd] and clear busy[wb_rd]. If an accept in the same cycle sets the same index, the set wins.
- Output drains when issued.valid && issued.ready and there is no new accept: out_valid goes to 0.
- Hold: while out_valid and !issued.ready, out_data stays stable.
- Flush:
  - out_valid goes to 0 and busy clears to all 0. A same-cycle accept is blocked.
  - A same-cycle writeback still updates regfile.
  - Contract: execute drops its in-flight work on flush, so no writeback from a killed instruction ever arrives.
- rst has priority over flush. flush has priority over accept.

## Timing

- Latency: accept in cycle N gives issued.valid in cycle N+1.
- Throughput: 1 instruction/cycle when there are no hazards and issued.ready is held high.
- A writeback in cycle N unblocks a dependent instruction in cycle N (bypass) and issues it in cycle N+1.
- A stalled instruction must be held by decode; this stage never drops decoded.valid work.
- busy[0] is never set.
- Register writes become visible to regfile reads from cycle N+1 onward.

## Configuration

- ISSUE_BYPASS_EN defined: same-cycle writeback forwarding is enabled, in both the hazard exceptions and operand selection, as described above.
- ISSUE_BYPASS_EN undefined:
  - Hazards ignore wb_*. An instruction stalls while busy[rsN] or busy[rd] is set.
  - Operands come only from regfile. The minimum dependent-issue delay is one extra cycle.
  - Writeback and scoreboard behaviour is otherwise unchanged.

## Test plan

- Reset, then issue "x1 <- op(x0,x0)" with issued.ready=1 -> issued.valid in the next cycle, rs1_val=rs2_val=0, busy[1]=1.
- Back-to-back independent instructions (rd 1,2,3) with ready=1 -> three issues in three consecutive cycles; decoded.ready never drops.
- Dependent "x2 <- x1" while busy[1]; wb x1=0xDEADBEEF in cycle N:
  - With ISSUE_BYPASS_EN: accepted in N with rs1_val=0xDEADBEEF.
  - Without ISSUE_BYPASS_EN: accepted in N+1.
- issued.ready=0 for 3 cycles with out_valid=1 -> out_data is stable and decoded.ready=0; on ready=1 the next instruction is accepted the same cycle.
- WAW: a second write to x5 while busy[5] -> stalls until wb x5, then sets busy[5] again, and busy[5] stays 1 after that wb cycle.
- Flush with out_valid=1, busy={1,4}, and a same-cycle wb x4=7:
  - Next cycle: out_valid=0, busy all 0, regfile[4]=7.
  - A decoded instruction in the flush cycle is not accepted.
